// File: rtl/pipe_controller.sv
// Pipelined RV32I control unit: decodes in D, carries the control bundle through E/M/W,
// resolves branch/jump redirection in E. Optional RV32M decode is enabled by RV32M_EN.
module pipe_controller #(
  parameter int   ALUCTRL_W    = 5,
  parameter logic RESET_PC_SRC = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic [6:0]           funct7D,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic [2:0]           ImmSrcD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcAE,
  output logic                 ALUSrcBE,
  output logic [1:0]           ResultSrcE,
  output logic [1:0]           ResultSrcM,
  output logic [1:0]           ResultSrcW,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic                 MemWriteM,
  output logic                 PCSrcE,
  output logic                 IllegalW
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01001;
  localparam logic [4:0] ALU_PASB = 5'b01010;

  typedef struct packed {
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 src_a;
    logic                 src_b;
    logic [2:0]           funct3;
    logic                 illegal;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       illegal;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_w_t;

  ctrl_e_t    dec, e_q;
  ctrl_m_t    m_q;
  ctrl_w_t    w_q;
  logic [4:0] alu;
  logic       bad;
  logic       cond;

  // Decode; shared by R-type and I-type ALU ops (funct3 -> operation)
  function automatic logic [4:0] f3_alu(input logic [2:0] f3, input logic arith);
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = arith ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec     = '0;
    ImmSrcD = 3'b000;
    alu     = ALU_ADD;
    bad     = 1'b0;
    case (opD)
      OP_R: begin
        dec.reg_write = 1'b1;
        case (funct7D)
          7'b0000000: alu = f3_alu(funct3D, 1'b0);
          7'b0100000: begin
            if (funct3D == 3'b000)      alu = ALU_SUB;
            else if (funct3D == 3'b101) alu = ALU_SRA;
            else                        bad = 1'b1;
          end
`ifdef RV32M_EN
          7'b0000001: alu = {2'b10, funct3D};
`endif
          default: bad = 1'b1;
        endcase
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.src_b     = 1'b1;
        alu           = f3_alu(funct3D, funct7D == 7'b0100000);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.src_b      = 1'b1;
        dec.result_src = 2'b01;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.src_b     = 1'b1;
        ImmSrcD       = 3'b001;
      end
      OP_BR: begin
        dec.branch = 1'b1;
        alu        = ALU_SUB;
        ImmSrcD    = 3'b010;
        bad        = (funct3D == 3'b010) || (funct3D == 3'b011);
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.src_a      = 1'b1;
        dec.src_b      = 1'b1;
        ImmSrcD        = 3'b011;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.src_b      = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.src_b     = 1'b1;
        alu           = ALU_PASB;
        ImmSrcD       = 3'b100;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.src_a     = 1'b1;
        dec.src_b     = 1'b1;
        ImmSrcD       = 3'b100;
      end
      default: bad = 1'b1;
    endcase
    dec.alu_ctrl = ALUCTRL_W'(alu);
    dec.funct3   = funct3D;
    dec.illegal  = bad;
    // An illegal slot must never write state or redirect fetch
    if (bad) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= FlushE ? '0 : dec;
      m_q <= '{reg_write: e_q.reg_write, result_src: e_q.result_src,
               mem_write: e_q.mem_write, illegal: e_q.illegal};
      w_q <= '{reg_write: m_q.reg_write, result_src: m_q.result_src,
               illegal: m_q.illegal};
    end
  end

  always_comb begin
    case (e_q.funct3)
      3'b000:  cond = ZeroE;
      3'b001:  cond = !ZeroE;
      3'b100:  cond = LtE;
      3'b101:  cond = !LtE;
      3'b110:  cond = LtuE;
      3'b111:  cond = !LtuE;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE      = reset ? RESET_PC_SRC : ((e_q.branch & cond) | e_q.jump);
  assign ALUControlE = e_q.alu_ctrl;
  assign ALUSrcAE    = e_q.src_a;
  assign ALUSrcBE    = e_q.src_b;
  assign ResultSrcE  = e_q.result_src;
  assign ResultSrcM  = m_q.result_src;
  assign MemWriteM   = m_q.mem_write;
  assign RegWriteM   = m_q.reg_write;
  assign ResultSrcW  = w_q.result_src;
  assign RegWriteW   = w_q.reg_write;
  assign IllegalW    = w_q.illegal;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed self-checking bench for pipe_controller: decode, pipeline latency, flush,
// branch resolution, async reset and illegal-instruction handling.
module tb_pipe_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opD, funct7D;
  logic [2:0] funct3D;
  logic       FlushE, ZeroE, LtE, LtuE;
  logic [2:0] ImmSrcD;
  logic [4:0] ALUControlE;
  logic       ALUSrcAE, ALUSrcBE;
  logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
  logic       RegWriteM, RegWriteW, MemWriteM, PCSrcE, IllegalW;
  int checks = 0;
  int errors = 0;

  pipe_controller #(.ALUCTRL_W(5), .RESET_PC_SRC(1'b0)) dut (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
    .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .ImmSrcD(ImmSrcD),
    .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemWriteM(MemWriteM),
    .PCSrcE(PCSrcE), .IllegalW(IllegalW)
  );

  always #5 clk = ~clk;

  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opD = op; funct3D = f3; funct7D = f7;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Not-taken beq: no writes, no redirect while ZeroE stays low
  task automatic filler(input int n);
    present(7'b1100011, 3'b000, 7'b0000000);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; FlushE = 1'b0; ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    present(7'b1101111, 3'b000, 7'b0000000);
    tick(); tick();
    checks++; if ({RegWriteM, RegWriteW, MemWriteM, IllegalW, ResultSrcE, ResultSrcM, ResultSrcW, ALUSrcAE, ALUSrcBE} !== 13'd0) begin
      errors++; $display("FAIL reset_regs got %b exp 0", {RegWriteM, RegWriteW, MemWriteM, IllegalW, ResultSrcE, ResultSrcM, ResultSrcW, ALUSrcAE, ALUSrcBE}); end
    checks++; if (ALUControlE !== 5'b00000) begin errors++; $display("FAIL reset_alu got %b exp 00000", ALUControlE); end
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL reset_pcsrc got %b exp 0", PCSrcE); end
    checks++; if (ImmSrcD !== 3'b011) begin errors++; $display("FAIL reset_immsrc_jal got %b exp 011", ImmSrcD); end
    reset = 1'b0;
    filler(3);
  endtask

  task automatic test_add();
    present(7'b0110011, 3'b000, 7'b0000000);
    tick();
    checks++; if (ALUControlE !== 5'b00000) begin errors++; $display("FAIL add_alu_e got %b exp 00000", ALUControlE); end
    checks++; if (ALUSrcBE !== 1'b0) begin errors++; $display("FAIL add_srcb_e got %b exp 0", ALUSrcBE); end
    filler(1);
    checks++; if (RegWriteM !== 1'b1) begin errors++; $display("FAIL add_regwrite_m got %b exp 1", RegWriteM); end
    tick();
    checks++; if (RegWriteW !== 1'b1 || ResultSrcW !== 2'b00) begin
      errors++; $display("FAIL add_w got rw=%b rs=%b exp rw=1 rs=00", RegWriteW, ResultSrcW); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [9] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011,
                            7'b0010011, 7'b0110111, 7'b0110011, 7'b1100011};
    logic [2:0] f3s [9] = '{3'b000, 3'b101, 3'b101, 3'b111, 3'b100, 3'b101, 3'b000, 3'b011, 3'b000};
    logic [6:0] f7s [9] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
    logic [4:0] alu [9] = '{5'b00001, 5'b01001, 5'b01000, 5'b00010, 5'b00100,
                            5'b01001, 5'b01010, 5'b00110, 5'b00001};
    logic       srcb [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      present(ops[i], f3s[i], f7s[i]);
      tick();
      checks++; if (ALUControlE !== alu[i] || ALUSrcBE !== srcb[i]) begin
        errors++; $display("FAIL b2b_%0d got alu=%b srcb=%b exp alu=%b srcb=%b", i, ALUControlE, ALUSrcBE, alu[i], srcb[i]); end
    end
    filler(3);
  endtask

  task automatic test_branch();
    present(7'b1100011, 3'b000, 7'b0000000);
    checks++; if (ImmSrcD !== 3'b010) begin errors++; $display("FAIL beq_immsrc got %b exp 010", ImmSrcD); end
    tick();
    ZeroE = 1'b1; #1;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", PCSrcE); end
    ZeroE = 1'b0; #1;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %b exp 0", PCSrcE); end
    present(7'b1100011, 3'b110, 7'b0000000);
    tick();
    LtuE = 1'b0; #1;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL bltu_not_taken got %b exp 0", PCSrcE); end
    LtuE = 1'b1; #1;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL bltu_taken got %b exp 1", PCSrcE); end
    LtuE = 1'b0;
    present(7'b1100011, 3'b101, 7'b0000000);
    tick();
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL bge_taken got %b exp 1", PCSrcE); end
    LtE = 1'b1; #1;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL bge_not_taken got %b exp 0", PCSrcE); end
    LtE = 1'b0;
    present(7'b1101111, 3'b000, 7'b0000000);
    tick();
    checks++; if (PCSrcE !== 1'b1 || ALUSrcAE !== 1'b1) begin
      errors++; $display("FAIL jal_e got pcsrc=%b srca=%b exp 1 1", PCSrcE, ALUSrcAE); end
    filler(2);
    checks++; if (ResultSrcW !== 2'b10 || RegWriteW !== 1'b1) begin
      errors++; $display("FAIL jal_w got rs=%b rw=%b exp 10 1", ResultSrcW, RegWriteW); end
  endtask

  task automatic test_flush();
    filler(3);
    present(7'b0000011, 3'b010, 7'b0000000);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    checks++; if (ResultSrcE !== 2'b00) begin errors++; $display("FAIL flush_lw_e got %b exp 00", ResultSrcE); end
    present(7'b1100011, 3'b000, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({RegWriteM, MemWriteM, RegWriteW, ResultSrcM, ResultSrcW} !== 7'd0) begin
        errors++; $display("FAIL flush_lw_down_%0d got %b exp 0", i, {RegWriteM, MemWriteM, RegWriteW, ResultSrcM, ResultSrcW}); end
      tick();
    end
    // Flush arriving while a taken branch sits in E
    tick();
    ZeroE = 1'b1; FlushE = 1'b1; #1;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL flush_taken_now got %b exp 1", PCSrcE); end
    tick();
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL flush_taken_next got %b exp 0", PCSrcE); end
    FlushE = 1'b0; ZeroE = 1'b0;
    filler(2);
  endtask

  task automatic test_reset_mid();
    present(7'b0100011, 3'b010, 7'b0000000);
    tick();
    filler(1);
    checks++; if (MemWriteM !== 1'b1) begin errors++; $display("FAIL sw_m got %b exp 1", MemWriteM); end
    #1 reset = 1'b1; #1;
    checks++; if (MemWriteM !== 1'b0) begin errors++; $display("FAIL rst_async_memw got %b exp 0", MemWriteM); end
    present(7'b0100011, 3'b010, 7'b0000000);
    tick();
    checks++; if (MemWriteM !== 1'b0 || ALUSrcBE !== 1'b0 || PCSrcE !== 1'b0) begin
      errors++; $display("FAIL rst_held got memw=%b srcb=%b pcsrc=%b exp 0 0 0", MemWriteM, ALUSrcBE, PCSrcE); end
    reset = 1'b0;
    filler(1);
    checks++; if (MemWriteM !== 1'b0) begin errors++; $display("FAIL rst_after1 got %b exp 0", MemWriteM); end
    tick();
    checks++; if (MemWriteM !== 1'b0) begin errors++; $display("FAIL rst_after2 got %b exp 0", MemWriteM); end
    present(7'b0100011, 3'b010, 7'b0000000);
    tick();
    filler(1);
    checks++; if (MemWriteM !== 1'b1) begin errors++; $display("FAIL sw_again_m got %b exp 1", MemWriteM); end
    filler(2);
  endtask

  task automatic test_rv32m();
    logic m_en;
`ifdef RV32M_EN
    m_en = 1'b1;
`else
    m_en = 1'b0;
`endif
    present(7'b0110011, 3'b000, 7'b0000001);
    tick();
    if (m_en) begin
      checks++; if (ALUControlE !== 5'b10000) begin errors++; $display("FAIL mul_alu_e got %b exp 10000", ALUControlE); end
    end
    // sll with the sub/sra funct7 is never legal
    present(7'b0110011, 3'b001, 7'b0100000);
    tick();
    filler(1);
    checks++; if (IllegalW !== !m_en || RegWriteW !== m_en) begin
      errors++; $display("FAIL mul_w got ill=%b rw=%b exp ill=%b rw=%b", IllegalW, RegWriteW, !m_en, m_en); end
    tick();
    checks++; if (IllegalW !== 1'b1 || RegWriteW !== 1'b0) begin
      errors++; $display("FAIL bad_f7_w got ill=%b rw=%b exp 1 0", IllegalW, RegWriteW); end
    filler(2);
  endtask

  task automatic test_illegal();
    ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1;
    present(7'b1111111, 3'b000, 7'b0000000);
    tick();
    checks++; if (PCSrcE !== 1'b0 || ResultSrcE !== 2'b00) begin
      errors++; $display("FAIL ill_e got pcsrc=%b rs=%b exp 0 00", PCSrcE, ResultSrcE); end
    present(7'b1100011, 3'b011, 7'b0000000);
    tick();
    checks++; if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || PCSrcE !== 1'b0) begin
      errors++; $display("FAIL ill_m got rw=%b mw=%b pcsrc=%b exp 0 0 0", RegWriteM, MemWriteM, PCSrcE); end
    ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    filler(1);
    checks++; if (IllegalW !== 1'b1 || RegWriteW !== 1'b0) begin
      errors++; $display("FAIL ill_w got ill=%b rw=%b exp 1 0", IllegalW, RegWriteW); end
    tick();
    checks++; if (IllegalW !== 1'b1 || RegWriteW !== 1'b0) begin
      errors++; $display("FAIL ill_br_w got ill=%b rw=%b exp 1 0", IllegalW, RegWriteW); end
    tick();
    checks++; if (IllegalW !== 1'b0) begin errors++; $display("FAIL ill_clear_w got %b exp 0", IllegalW); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_flush();
    test_reset_mid();
    test_rv32m();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_controller.md
# pipe_controller

Parametrised, pipelined control unit for the five-stage RV32I core. Decodes the instruction held in the Decode stage (op, funct3, full funct7) into a control bundle. Carries that bundle through the Execute, Memory and Writeback control registers under hazard-unit flush control. Resolves branch and jump redirection in Execute for all six RV32I branch conditions.

## Interface
- `ALUCTRL_W`, default 5, ALU control width; must be ≥ 5.
- `RESET_PC_SRC`, default 0, value driven on PCSrcE while reset is asserted.
- `clk`  in  1  core clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears every stage register to a bubble.
- `opD`  in  7  Decode-stage opcode.
- `funct3D`  in  3  Decode-stage funct3.
- `funct7D`  in  7  Decode-stage funct7 (full field).
- `FlushE`  in  1  from hazard unit; loads a bubble into the Execute control register.
- `ZeroE`, `LtE`, `LtuE`  in  1 each  ALU comparator flags: equal, signed less-than, unsigned less-than.
- `ImmSrcD`  out  3  I=000, S=001, B=010, J=011, U=100 (combinational from Decode).
- `ALUControlE`  out  ALUCTRL_W  ALU operation in Execute.
- `ALUSrcAE`  out  1  1 = PC as operand A (auipc, jal).
- `ALUSrcBE`  out  1  1 = immediate as operand B.
- `ResultSrcE`, `ResultSrcM`, `ResultSrcW`  out  2 each  00 ALU, 01 memory, 10 PC+4; ResultSrcE[0] feeds load-use detection.
- `RegWriteM`, `RegWriteW`  out  1 each  register-file write enable per stage.
- `MemWriteM`  out  1  data-memory write.
- `PCSrcE`  out  1  redirect fetch to the branch or jump target.
- `IllegalW`  out  1  retiring slot held an illegal instruction.

## Operation
- **Decode (combinational)**
  - Supported opcodes: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
  - ALUControl codes: add 00000, sub 00001, and 00010, or 00011, xor 00100, slt 00101, sltu 00110, sll 00111, srl 01000, sra 01001, passB 01010 (lui).
  - sub is selected for R-type when funct7D = 0100000. sra is selected when funct3 = 101 and funct7D = 0100000.
  - Loads, stores, jalr and auipc use add. Branches use sub.
- **Illegal instruction**
  - Any unlisted opcode, or an R-type funct7D other than 0000000 or 0100000 (subject to Configuration), or a 0100000 pairing other than with add/sra, is illegal.
  - The illegal flag rides the pipe, and the slot's RegWrite, MemWrite, Branch and Jump are forced to 0.
- **Pipeline registers**
  - The D→E register captures the full bundle plus Branch, Jump, funct3 and Illegal.
  - E→M and M→W capture the subsets needed downstream. E→M and M→W are never stalled or flushed.
- **Bubble**
  - A bubble is all enables 0, ALUControl 0, ResultSrc 00 and Illegal 0.
  - FlushE, or reset, loads a bubble into E.
- **Branch resolution in E**
  - taken = BranchE & (beq: ZeroE; bne: !ZeroE; blt: LtE; bge: !LtE; bltu: LtuE; bgeu: !LtuE). funct3 values 010 and 011 are illegal in Decode.
  - PCSrcE = taken | JumpE.

## Timing
- Decode→E latency is 1 cycle; →M is 2; →W is 3.
- ImmSrcD is combinational from the D inputs.
- PCSrcE is combinational from the E register and the flags; there is no added latency.
- Reset
  - Asynchronous assert: every registered output goes to 0 immediately. PCSrcE = RESET_PC_SRC.
  - Deassert: the first rising edge captures the D inputs.
  - Reset mid-operation discards all in-flight control with no partial writes.
- Simultaneous events
  - FlushE together with a valid D instruction: E becomes a bubble, and the instruction is lost (the hazard unit re-presents it).
  - FlushE together with a taken branch in E: PCSrcE reflects the current E contents this cycle; the flush takes effect on the next edge.

## Configuration
- `RV32M_EN` defined: an R-type instruction with funct7D = 0000001 decodes to ALUControl = {2'b10, funct3D} (mul 10000 … remu 10111). It is legal with RegWrite = 1.
- `RV32M_EN` undefined: funct7D = 0000001 on an R-type is illegal.

## Test plan
- Reset, then add (op 0110011, f3 000, f7 0000000): the cycle after it is presented, ALUControlE = 00000; RegWriteM = 1 one cycle later; RegWriteW = 1 one cycle after that.
- beq with ZeroE = 1 in E: PCSrcE = 1. bltu with LtuE = 0: PCSrcE = 0. jal: PCSrcE = 1 and ResultSrcW = 10.
- lw presented with FlushE = 1 on the capture edge: ResultSrcE = 00, and no MemWrite or RegWrite ever appears downstream.
- sw in E, then reset asserted mid-cycle: MemWriteM = 0 immediately, and remains 0 after deassert until a new sw arrives.
- R-type with funct7D = 0000001, f3 = 000: with RV32M_EN, ALUControlE = 10000 and IllegalW = 0. Without it, IllegalW = 1 three cycles later and RegWriteW = 0.
- Opcode 1111111: IllegalW = 1 at the W stage, and all write enables are 0 in every stage.
